// File: rtl/spi_frame_slave_pkg.sv
// spi_frame_slave_pkg: frame geometry, command codes, FSM encoding and clock constants
package spi_frame_slave_pkg;
   localparam int FRAME_WIDTH = 24;
   localparam int CMD_BITS = 8;
   localparam int ADDR_BITS = 8;
   localparam int PAYLOAD_BITS = 8;
   localparam logic [CMD_BITS-1:0] CMD_LED_SET = 8'h01;
   localparam int SYSCLK_PERIOD_NS = 8;
   localparam int SCLK_MIN_PERIOD_NS = 38;
   typedef enum logic [3:0] {
      IDLE = 4'd0,
      RX_CMD = 4'd1,
      RX_ADDR = 4'd2,
      RX_PAYLOAD = 4'd3,
      DONE = 4'd4
   } state_t;
   function automatic state_t next_field(input state_t s);
      return s == RX_CMD ? RX_ADDR : s == RX_ADDR ? RX_PAYLOAD : DONE;
   endfunction
endpackage

// File: rtl/spi_frame_slave_if.sv
// spi_frame_slave_if: SPI pins, response frame input and parsed-frame/debug outputs
interface spi_frame_slave_if;
   import spi_frame_slave_pkg::*;
   logic sclk;
   logic cs;
   logic mosi;
   logic miso;
   logic slv_tx_enb;
   logic [FRAME_WIDTH-1:0] i_slv_frame;
   logic [CMD_BITS-1:0] o_cmd;
   logic [ADDR_BITS-1:0] o_addr;
   logic [PAYLOAD_BITS-1:0] o_payload;
   logic rx_dv;
   logic [FRAME_WIDTH-1:0] o_shift_reg_debug;
   logic o_serial_debug;
   logic [3:0] o_bit_rx_cnt_debug;
   logic [3:0] o_debug_stage;
   modport slave (
      input sclk, cs, mosi, slv_tx_enb, i_slv_frame,
      output miso, o_cmd, o_addr, o_payload, rx_dv,
             o_shift_reg_debug, o_serial_debug, o_bit_rx_cnt_debug, o_debug_stage
   );
   modport master (
      output sclk, cs, mosi, slv_tx_enb, i_slv_frame,
      input miso, o_cmd, o_addr, o_payload, rx_dv,
            o_shift_reg_debug, o_serial_debug, o_bit_rx_cnt_debug, o_debug_stage
   );
endinterface

// File: rtl/spi_frame_slave_sync_edge.sv
// spi_sync_edge: 2-FF synchroniser with a history stage for rise/fall detection
module spi_sync_edge (
   input  logic sysclk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);
   logic [2:0] sh_q, sh_d;
   always_comb sh_d = {sh_q[1:0], d};
   always_ff @(posedge sysclk) sh_q <= rst_n ? sh_d : '0;
   assign rise = sh_q[1] & ~sh_q[2];
   assign fall = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/spi_frame_slave.sv
// spi_frame_slave: oversampled SPI mode-0 slave for 24-bit frames; SPI_SLAVE_DEBUG_EN exposes internal state
module spi_frame_slave
   import spi_frame_slave_pkg::*;
(
   input logic sysclk,
   input logic rst_n,
   spi_frame_slave_if.slave bus
);
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [1:0] mosi_q, mosi_d;
   state_t state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [FRAME_WIDTH-1:0] rx_q, rx_d, tx_q, tx_d;
   logic [CMD_BITS-1:0] cmd_q, cmd_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [PAYLOAD_BITS-1:0] pay_q, pay_d;
   logic dv_q, dv_d, miso_q, miso_d;
   spi_sync_edge u_sclk (.sysclk(sysclk), .rst_n(rst_n), .d(bus.sclk), .rise(sclk_rise), .fall(sclk_fall));
   spi_sync_edge u_cs (.sysclk(sysclk), .rst_n(rst_n), .d(bus.cs), .rise(cs_rise), .fall(cs_fall));
   always_comb mosi_d = {mosi_q[0], bus.mosi};
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      rx_d = rx_q;
      tx_d = tx_q;
      cmd_d = cmd_q;
      addr_d = addr_q;
      pay_d = pay_q;
      dv_d = 1'b0;
      if (state_q == IDLE) begin
         if (cs_fall) begin
            state_d = RX_CMD;
            cnt_d = '0;
            rx_d = '0;
            tx_d = bus.slv_tx_enb ? bus.i_slv_frame : '0;
         end
      end else if (state_q == DONE) begin
         if (cs_rise) begin
            state_d = IDLE;
            cmd_d = rx_q[FRAME_WIDTH-1 -: CMD_BITS];
            addr_d = rx_q[PAYLOAD_BITS +: ADDR_BITS];
            pay_d = rx_q[PAYLOAD_BITS-1:0];
            dv_d = 1'b1;
         end
      end else if (cs_rise) begin
         state_d = IDLE;
      end else begin
         if (sclk_fall) tx_d = {tx_q[FRAME_WIDTH-2:0], 1'b0};
         if (sclk_rise) begin
            rx_d = {rx_q[FRAME_WIDTH-2:0], mosi_q[1]};
            cnt_d = cnt_q == 4'd7 ? 4'd0 : cnt_q + 4'd1;
            state_d = cnt_q == 4'd7 ? next_field(state_q) : state_q;
         end
      end
      // miso is registered from the next-state tx MSB so bit 23 appears in the cs-fall cycle
      miso_d = state_d != IDLE && tx_d[FRAME_WIDTH-1];
   end
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         mosi_q <= '0;
         state_q <= IDLE;
         cnt_q <= '0;
         rx_q <= '0;
         tx_q <= '0;
         cmd_q <= '0;
         addr_q <= '0;
         pay_q <= '0;
         dv_q <= 1'b0;
         miso_q <= 1'b0;
      end else begin
         mosi_q <= mosi_d;
         state_q <= state_d;
         cnt_q <= cnt_d;
         rx_q <= rx_d;
         tx_q <= tx_d;
         cmd_q <= cmd_d;
         addr_q <= addr_d;
         pay_q <= pay_d;
         dv_q <= dv_d;
         miso_q <= miso_d;
      end
   end
   assign bus.miso = miso_q;
   assign bus.o_cmd = cmd_q;
   assign bus.o_addr = addr_q;
   assign bus.o_payload = pay_q;
   assign bus.rx_dv = dv_q;
`ifdef SPI_SLAVE_DEBUG_EN
   logic serial_q, serial_d;
   always_comb serial_d = state_q != IDLE && state_q != DONE && sclk_rise ? mosi_q[1] : serial_q;
   always_ff @(posedge sysclk) serial_q <= rst_n ? serial_d : 1'b0;
   assign bus.o_shift_reg_debug = rx_q;
   assign bus.o_serial_debug = serial_q;
   assign bus.o_bit_rx_cnt_debug = cnt_q;
   assign bus.o_debug_stage = state_q;
`else
   assign bus.o_shift_reg_debug = '0;
   assign bus.o_serial_debug = 1'b0;
   assign bus.o_bit_rx_cnt_debug = '0;
   assign bus.o_debug_stage = '0;
`endif
endmodule

// File: tb/tb_spi_frame_slave.sv
// tb_spi_frame_slave: randomized SPI master with a queue scoreboard of expected published frames
module tb_spi_frame_slave;
   import spi_frame_slave_pkg::*;
   logic sysclk = 1'b0;
   logic rst_n = 1'b0;
   int errors = 0;
   int checks = 0;
   logic [23:0] exp_q[$];
   logic [23:0] last_pub = '0;
   logic prev_dv = 1'b0;
   spi_frame_slave_if bus ();
   spi_frame_slave dut (.sysclk(sysclk), .rst_n(rst_n), .bus(bus));
   always #(SYSCLK_PERIOD_NS / 2) sysclk = ~sysclk;
   task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge sysclk);
   endtask
   always @(negedge sysclk) begin
      if (rst_n && bus.rx_dv) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_dv: got unexpected pulse expected none");
         end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            chk("o_cmd", {16'h0, bus.o_cmd}, {16'h0, e[23:16]});
            chk("o_addr", {16'h0, bus.o_addr}, {16'h0, e[15:8]});
            chk("o_payload", {16'h0, bus.o_payload}, {16'h0, e[7:0]});
            chk("rx_dv_width", {23'h0, prev_dv}, 24'h0);
         end
      end
      prev_dv = bus.rx_dv;
   end
   task automatic check_idle_outputs(input logic [23:0] pub);
      chk("hold_cmd", {16'h0, bus.o_cmd}, {16'h0, pub[23:16]});
      chk("hold_addr", {16'h0, bus.o_addr}, {16'h0, pub[15:8]});
      chk("hold_payload", {16'h0, bus.o_payload}, {16'h0, pub[7:0]});
      chk("stage", {20'h0, bus.o_debug_stage}, 24'h0);
      chk("miso_idle", {23'h0, bus.miso}, 24'h0);
   endtask
   // Drives one transaction; rst_at >= 0 pulses rst_n low for 2 cycles before that bit
   task automatic send_frame(input logic [23:0] m, input logic en, input logic [23:0] s,
                             input int nbits, input int rst_at);
      int hp;
      logic [23:0] cap;
      hp = int'($urandom_range(4, 7));
      cap = '0;
      bus.slv_tx_enb = en;
      bus.i_slv_frame = s;
      bus.sclk = 1'b0;
      bus.mosi = m[23];
      bus.cs = 1'b0;
      tick(hp + 1);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_at) begin
            rst_n = 1'b0;
            tick(2);
            rst_n = 1'b1;
            tick(1);
            last_pub = '0;
            check_idle_outputs(24'h0);
            chk("rx_dv_reset", {23'h0, bus.rx_dv}, 24'h0);
         end
         if (i == 5) begin
            bus.i_slv_frame = $urandom;
            bus.slv_tx_enb = ~en;
         end
         bus.mosi = m[23-i];
         tick(hp);
         cap = {cap[22:0], bus.miso};
         bus.sclk = 1'b1;
         tick(hp);
         bus.sclk = 1'b0;
      end
      tick(hp);
      if (nbits == 24 && rst_at < 0) begin
         exp_q.push_back(m);
         last_pub = m;
      end
      bus.cs = 1'b1;
      tick(hp + 8);
      if (nbits == 24 && rst_at < 0) chk("miso_frame", cap, en ? s : 24'h0);
      if (nbits < 24) check_idle_outputs(last_pub);
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
   initial begin
      bus.sclk = 1'b0;
      bus.cs = 1'b1;
      bus.mosi = 1'b0;
      bus.slv_tx_enb = 1'b0;
      bus.i_slv_frame = '0;
      tick(4);
      check_idle_outputs(24'h0);
      chk("rx_dv_rst", {23'h0, bus.rx_dv}, 24'h0);
      rst_n = 1'b1;
      tick(6);
      send_frame(24'h81A1D1, 1'b0, 24'hFFFFFF, 24, -1);
      send_frame({CMD_LED_SET, 8'h02, 8'h0A}, 1'b0, 24'h000000, 24, -1);
      send_frame(24'h010905, 1'b1, 24'h00000A, 24, -1);
      send_frame(24'hC3C3C3, 1'b1, 24'h5A5A5A, 12, -1);
      send_frame(24'h777777, 1'b1, 24'h123123, 24, 12);
      tick(10);
      send_frame(24'h123456, 1'b1, 24'hF0F00F, 24, -1);
      send_frame(24'hAAAAAA, 1'b0, 24'h0, 24, -1);
      tick(20);
      send_frame(24'h555555, 1'b1, 24'hA5A5A5, 24, -1);
      for (int k = 0; k < 20; k++) begin
         send_frame(24'($urandom), 1'($urandom), 24'($urandom),
                    $urandom_range(0, 3) == 0 ? int'($urandom_range(1, 23)) : 24, -1);
         tick(int'($urandom_range(2, 20)));
      end
      tick(30);
      chk("scoreboard_empty", 24'(exp_q.size()), 24'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
